// File: rtl/dmem_bus_bridge_pkg.sv
// Shared types and helpers for the data-memory bus bridge:
// load/store mode encodings, FSM state codes and the alignment rule.
package dmem_bus_bridge_pkg;

    localparam int WORD_WIDTH = 32;
    localparam int L_S_MODE_W = 3;

    typedef enum logic [L_S_MODE_W-1:0] {
        LS_W  = 3'd0,
        LS_H  = 3'd1,
        LS_HU = 3'd2,
        LS_B  = 3'd3,
        LS_BU = 3'd4
    } ls_mode_e;

    typedef enum logic [1:0] {
        BR_IDLE = 2'd0,
        BR_REQ  = 2'd1,
        BR_DONE = 2'd2
    } br_state_e;

    // Word needs addr[1:0]==0, halfword needs addr[0]==0; bytes are always aligned.
    function automatic logic is_misaligned(input logic [L_S_MODE_W-1:0] mode,
                                           input logic [1:0]            addr_lo);
        logic result;
        case (mode)
            LS_W:        result = (addr_lo != 2'b00);
            LS_H, LS_HU: result = addr_lo[0];
            default:     result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/dmem_bus_bridge_if.sv
// Word bus between the bridge (master) and the data memory slave.
// valid/ready handshake, one transfer per request.
interface dmem_bus_bridge_if
    import dmem_bus_bridge_pkg::*;
#(
    parameter int W = WORD_WIDTH
);
    logic         bus_valid;
    logic         bus_we;
    logic [W-1:0] bus_addr;
    logic [W-1:0] bus_wdata;
    logic [3:0]   bus_be;
    logic         bus_ready;
    logic [W-1:0] bus_rdata;

    modport master (
        output bus_valid, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  bus_valid, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_ready, bus_rdata
    );
endinterface

// File: rtl/dmem_bus_bridge_lane_align.sv
// Combinational byte-lane steering: store replication/byte enables from live CPU
// inputs, and load extraction/extension from the latched mode and address offset.
module dmem_bus_bridge_lane_align
    import dmem_bus_bridge_pkg::*;
(
    input  logic [L_S_MODE_W-1:0] st_mode,
    input  logic [1:0]            st_addr_lo,
    input  logic [WORD_WIDTH-1:0] s_data,
    output logic [WORD_WIDTH-1:0] st_wdata,
    output logic [3:0]            st_be,
    input  logic [L_S_MODE_W-1:0] ld_mode,
    input  logic [1:0]            ld_addr_lo,
    input  logic [WORD_WIDTH-1:0] rdata,
    output logic [WORD_WIDTH-1:0] ld_data
);

    logic [7:0]  ld_byte_s;
    logic [15:0] ld_half_s;

    // Store lanes: narrow data is replicated so the slave only needs byte enables.
    always_comb begin
        st_wdata = s_data;
        st_be    = 4'b1111;
        case (st_mode)
            LS_B, LS_BU: begin
                st_wdata = {4{s_data[7:0]}};
                st_be    = 4'b0001 << st_addr_lo;
            end
            LS_H, LS_HU: begin
                st_wdata = {2{s_data[15:0]}};
                st_be    = st_addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = s_data;
                st_be    = 4'b1111;
            end
        endcase
    end

    // Pick the addressed byte and halfword out of the returned word.
    always_comb begin
        ld_byte_s = rdata[7:0];
        case (ld_addr_lo)
            2'd0:    ld_byte_s = rdata[7:0];
            2'd1:    ld_byte_s = rdata[15:8];
            2'd2:    ld_byte_s = rdata[23:16];
            2'd3:    ld_byte_s = rdata[31:24];
            default: ld_byte_s = rdata[7:0];
        endcase
        if (ld_addr_lo[1]) begin
            ld_half_s = rdata[31:16];
        end else begin
            ld_half_s = rdata[15:0];
        end
    end

    // Sign or zero extend the extracted lane to a full word.
    always_comb begin
        ld_data = rdata;
        case (ld_mode)
            LS_B:    ld_data = {{24{ld_byte_s[7]}}, ld_byte_s};
            LS_BU:   ld_data = {24'd0, ld_byte_s};
            LS_H:    ld_data = {{16{ld_half_s[15]}}, ld_half_s};
            LS_HU:   ld_data = {16'd0, ld_half_s};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_bus_bridge.sv
// Data-side memory stage: turns each CPU load/store into one bus transfer,
// stalls the CPU until it completes, and flags misalignment and bus timeouts.
module dmem_bus_bridge
    import dmem_bus_bridge_pkg::*;
#(
    parameter int W       = WORD_WIDTH,
    parameter int TIMEOUT = 16
)(
    input  logic                  main_clk,
    input  logic                  rst,
    input  logic                  load_en,
    input  logic                  store_en,
    input  logic [W-1:0]          addr,
    input  logic [W-1:0]          s_data,
    input  logic [L_S_MODE_W-1:0] l_s_mode,
    output logic [W-1:0]          l_data,
    output logic                  stall,
    output logic                  misalign,
    output logic                  bus_err,
    dmem_bus_bridge_if.master     bus
);

    localparam int CNT_W = $clog2(TIMEOUT);

    br_state_e             state_r;
    br_state_e             state_nxt_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [L_S_MODE_W-1:0] ld_mode_r;
    logic [1:0]            ld_addr_lo_r;

    logic                  req_s;
    logic                  misaligned_s;
    logic                  timeout_s;
    logic                  accept_s;
    logic                  complete_s;
    logic                  abort_s;
    logic [W-1:0]          st_wdata_s;
    logic [3:0]            st_be_s;
    logic [W-1:0]          ld_data_s;

    assign req_s        = load_en | store_en;
    assign misaligned_s = is_misaligned(l_s_mode, addr[1:0]);
    assign timeout_s    = (cnt_r == CNT_W'(TIMEOUT - 1));

    // CPU-facing status is combinational so the pipeline freezes in the request cycle.
    assign misalign = req_s && (state_r == BR_IDLE) && misaligned_s;
    assign stall    = req_s && !misaligned_s && (state_r != BR_DONE);

    dmem_bus_bridge_lane_align u_lane_align (
        .st_mode    (l_s_mode),
        .st_addr_lo (addr[1:0]),
        .s_data     (s_data),
        .st_wdata   (st_wdata_s),
        .st_be      (st_be_s),
        .ld_mode    (ld_mode_r),
        .ld_addr_lo (ld_addr_lo_r),
        .rdata      (bus.bus_rdata),
        .ld_data    (ld_data_s)
    );

    // Next-state and transfer event decode.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        complete_s  = 1'b0;
        abort_s     = 1'b0;
        case (state_r)
            BR_IDLE: begin
                if (req_s && !misaligned_s) begin
                    state_nxt_s = BR_REQ;
                    accept_s    = 1'b1;
                end else begin
                    state_nxt_s = BR_IDLE;
                end
            end
            BR_REQ: begin
                if (bus.bus_ready) begin
                    state_nxt_s = BR_DONE;
                    complete_s  = 1'b1;
                end else if (timeout_s) begin
                    state_nxt_s = BR_DONE;
                    abort_s     = 1'b1;
                end else begin
                    state_nxt_s = BR_REQ;
                end
            end
            BR_DONE: state_nxt_s = BR_IDLE;
            default: state_nxt_s = BR_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge main_clk or negedge rst) begin
        if (!rst) begin
            state_r <= BR_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Wait-state counter; only advances while the slave withholds ready.
    always_ff @(posedge main_clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == BR_REQ) && !bus.bus_ready && !timeout_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Bus payload is captured once on accept and held stable until completion.
    always_ff @(posedge main_clk or negedge rst) begin
        if (!rst) begin
            bus.bus_valid <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= {W{1'b0}};
            bus.bus_wdata <= {W{1'b0}};
            bus.bus_be    <= 4'b0000;
            ld_mode_r     <= LS_W;
            ld_addr_lo_r  <= 2'b00;
        end else if (accept_s) begin
            bus.bus_valid <= 1'b1;
            bus.bus_we    <= store_en;
            bus.bus_addr  <= {addr[W-1:2], 2'b00};
            bus.bus_wdata <= st_wdata_s;
            bus.bus_be    <= st_be_s;
            ld_mode_r     <= l_s_mode;
            ld_addr_lo_r  <= addr[1:0];
        end else if (complete_s || abort_s) begin
            bus.bus_valid <= 1'b0;
        end else begin
            bus.bus_valid <= bus.bus_valid;
        end
    end

    // Load result and timeout pulse, both visible during DONE.
    always_ff @(posedge main_clk or negedge rst) begin
        if (!rst) begin
            l_data  <= {W{1'b0}};
            bus_err <= 1'b0;
        end else begin
            bus_err <= abort_s;
            if (complete_s && !bus.bus_we) begin
                l_data <= ld_data_s;
            end else if (abort_s && !bus.bus_we) begin
                l_data <= {W{1'b0}};
            end else begin
                l_data <= l_data;
            end
        end
    end

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Scoreboard bench for dmem_bus_bridge: directed accesses push expected bus
// payloads and results; a negedge monitor checks them as the DUT presents them.
module tb_dmem_bus_bridge;
    import dmem_bus_bridge_pkg::*;

    localparam int TIMEOUT = 16;
    localparam int NEVER   = 1000;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] ldata;
        logic        err;
        int          stall_cyc;
    } exp_t;

    logic        main_clk;
    logic        rst;
    logic        load_en;
    logic        store_en;
    logic [31:0] addr;
    logic [31:0] s_data;
    logic [2:0]  l_s_mode;
    logic [31:0] l_data;
    logic        stall;
    logic        misalign;
    logic        bus_err;

    dmem_bus_bridge_if #(.W(32)) bus ();

    dmem_bus_bridge #(.W(32), .TIMEOUT(TIMEOUT)) dut (
        .main_clk (main_clk),
        .rst      (rst),
        .load_en  (load_en),
        .store_en (store_en),
        .addr     (addr),
        .s_data   (s_data),
        .l_s_mode (l_s_mode),
        .l_data   (l_data),
        .stall    (stall),
        .misalign (misalign),
        .bus_err  (bus_err),
        .bus      (bus)
    );

    int          checks;
    int          failures;
    int          issued;
    int          completed;
    exp_t        exp_q[$];
    int          mis_q[$];
    int          ready_delay;
    logic [31:0] rdata_val;
    logic [31:0] last_ldata;

    initial begin
        main_clk = 1'b0;
        forever #5 main_clk = ~main_clk;
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h @%0t", name, act, exp, $time);
        end
    endfunction

    // Slave model: raises ready after ready_delay wait states of a held request.
    int wait_cnt;
    always @(negedge main_clk) begin
        bus.bus_rdata = rdata_val;
        if (!rst || !bus.bus_valid) begin
            wait_cnt      = 0;
            bus.bus_ready = 1'b0;
        end else begin
            bus.bus_ready = (wait_cnt == ready_delay);
            wait_cnt++;
        end
    end

    // Monitor: payload checked every REQ cycle, result checked in the DONE cycle.
    int   valid_cnt;
    int   stall_cnt;
    logic prev_valid;
    always @(negedge main_clk) begin
        exp_t e;
        if (!rst) begin
            if (valid_cnt > 0 && exp_q.size() > 0) void'(exp_q.pop_front());
            valid_cnt  = 0;
            stall_cnt  = 0;
            prev_valid = 1'b0;
        end else begin
            if (bus.bus_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'(bus.bus_valid), 32'd0);
                end else begin
                    e = exp_q[0];
                    check("bus_we",    32'(bus.bus_we), 32'(e.we));
                    check("bus_addr",  bus.bus_addr,    e.addr);
                    check("bus_wdata", bus.bus_wdata,   e.wdata);
                    check("bus_be",    32'(bus.bus_be), 32'(e.be));
                end
                check("err_in_req", 32'(bus_err), 32'd0);
                valid_cnt++;
            end else if (prev_valid) begin
                if (exp_q.size() == 0) begin
                    check("done_without_exp", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("l_data",      l_data,           e.ldata);
                    check("bus_err",     32'(bus_err),     32'(e.err));
                    check("stall_cyc",   32'(stall_cnt),   32'(e.stall_cyc));
                    check("valid_cyc",   32'(valid_cnt),   32'(e.stall_cyc - 1));
                    check("stall_done",  32'(stall),       32'd0);
                end
                completed++;
                valid_cnt = 0;
                stall_cnt = 0;
            end else begin
                check("err_idle", 32'(bus_err), 32'd0);
            end
            if (stall) stall_cnt++;
            if (misalign) begin
                if (mis_q.size() == 0) begin
                    check("unexpected_misalign", 32'd1, 32'd0);
                end else begin
                    void'(mis_q.pop_front());
                    check("misalign_stall", 32'(stall), 32'd0);
                    check("misalign_valid", 32'(bus.bus_valid), 32'd0);
                end
            end
            prev_valid = bus.bus_valid;
        end
    end

    task automatic drive(input logic ld, input logic st, input logic [31:0] a,
                         input logic [31:0] sd, input logic [2:0] mode);
        load_en  = ld;
        store_en = st;
        addr     = a;
        s_data   = sd;
        l_s_mode = mode;
    endtask

    task automatic access(input logic ld, input logic st, input logic [31:0] a,
                          input logic [31:0] sd, input logic [2:0] mode,
                          input int delay, input logic [31:0] rd,
                          input logic [31:0] wdata_exp, input logic [3:0] be_exp,
                          input logic [31:0] ldata_exp, input logic err_exp,
                          input int stall_exp);
        exp_t e;
        e.we        = st;
        e.addr      = {a[31:2], 2'b00};
        e.wdata     = wdata_exp;
        e.be        = be_exp;
        e.ldata     = ldata_exp;
        e.err       = err_exp;
        e.stall_cyc = stall_exp;
        exp_q.push_back(e);
        issued++;
        last_ldata  = ldata_exp;
        ready_delay = delay;
        rdata_val   = rd;
        @(posedge main_clk); #2;
        drive(ld, st, a, sd, mode);
        for (int i = 0; i < 100; i++) begin
            @(posedge main_clk); #2;
            if (!stall) break;
        end
        check("stall_release", 32'(stall), 32'd0);
        drive(1'b0, 1'b0, 32'd0, 32'd0, LS_W);
        @(posedge main_clk); #2;
    endtask

    initial begin
        checks = 0; failures = 0; issued = 0; completed = 0;
        ready_delay = 0; rdata_val = 32'd0; last_ldata = 32'd0;
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 32'd0, LS_W);
        repeat (3) @(posedge main_clk);
        @(negedge main_clk);
        check("rst_valid", 32'(bus.bus_valid), 32'd0);
        check("rst_we",    32'(bus.bus_we),    32'd0);
        check("rst_addr",  bus.bus_addr,       32'd0);
        check("rst_wdata", bus.bus_wdata,      32'd0);
        check("rst_be",    32'(bus.bus_be),    32'd0);
        check("rst_ldata", l_data,             32'd0);
        check("rst_err",   32'(bus_err),       32'd0);
        check("rst_stall", 32'(stall),         32'd0);
        @(posedge main_clk); #2;
        rst = 1'b1;

        // ld st addr sd mode delay rdata | wdata be ldata err stall
        access(1'b1, 1'b0, 32'h100, 32'h0, LS_W, 0, 32'hDEADBEEF,
               32'h0, 4'b1111, 32'hDEADBEEF, 1'b0, 2);
        access(1'b0, 1'b1, 32'h103, 32'hA5, LS_B, 0, 32'h0,
               32'hA5A5A5A5, 4'b1000, 32'hDEADBEEF, 1'b0, 2);
        access(1'b1, 1'b0, 32'h102, 32'h0, LS_H, 0, 32'h80011234,
               32'h0, 4'b1100, 32'hFFFF8001, 1'b0, 2);
        access(1'b1, 1'b0, 32'h102, 32'h0, LS_HU, 0, 32'h80011234,
               32'h0, 4'b1100, 32'h00008001, 1'b0, 2);
        access(1'b1, 1'b0, 32'h101, 32'h0, LS_B, 0, 32'h00007F00,
               32'h0, 4'b0010, 32'h0000007F, 1'b0, 2);
        access(1'b1, 1'b0, 32'h103, 32'h0, LS_B, 0, 32'h9A000000,
               32'h0, 4'b1000, 32'hFFFFFF9A, 1'b0, 2);
        access(1'b0, 1'b1, 32'h202, 32'h0000BEEF, LS_H, 5, 32'h0,
               32'hBEEFBEEF, 4'b1100, 32'hFFFFFF9A, 1'b0, 7);
        access(1'b1, 1'b1, 32'h304, 32'h11223344, LS_W, 1, 32'h55555555,
               32'h11223344, 4'b1111, 32'hFFFFFF9A, 1'b0, 3);
        access(1'b1, 1'b0, 32'h400, 32'h0, LS_W, NEVER, 32'h77777777,
               32'h0, 4'b1111, 32'h0, 1'b1, TIMEOUT + 1);
        access(1'b1, 1'b0, 32'h404, 32'h0, LS_W, 1, 32'hCAFEF00D,
               32'h0, 4'b1111, 32'hCAFEF00D, 1'b0, 3);

        // Misaligned word and halfword: one cycle each, no bus activity.
        mis_q.push_back(1);
        @(posedge main_clk); #2;
        drive(1'b1, 1'b0, 32'h102, 32'h0, LS_W);
        @(posedge main_clk); #2;
        mis_q.push_back(1);
        drive(1'b0, 1'b1, 32'h101, 32'h1234, LS_H);
        @(posedge main_clk); #2;
        drive(1'b0, 1'b0, 32'd0, 32'd0, LS_W);
        repeat (2) @(posedge main_clk);
        #2;

        // Reset in the middle of a stalled request.
        begin
            exp_t e;
            e.we = 1'b0; e.addr = 32'h500; e.wdata = 32'h0; e.be = 4'b1111;
            e.ldata = 32'h0; e.err = 1'b0; e.stall_cyc = 0;
            exp_q.push_back(e);
        end
        ready_delay = NEVER;
        drive(1'b1, 1'b0, 32'h500, 32'h0, LS_W);
        repeat (4) @(posedge main_clk);
        #2;
        rst = 1'b0;
        #1;
        check("midreq_valid", 32'(bus.bus_valid), 32'd0);
        check("midreq_addr",  bus.bus_addr,       32'd0);
        check("midreq_ldata", l_data,             32'd0);
        @(posedge main_clk); #2;
        drive(1'b0, 1'b0, 32'd0, 32'd0, LS_W);
        @(posedge main_clk); #2;
        rst = 1'b1;

        access(1'b1, 1'b0, 32'h503, 32'h0, LS_BU, 0, 32'h80000000,
               32'h0, 4'b1000, 32'h00000080, 1'b0, 2);

        repeat (3) @(posedge main_clk);
        #2;
        check("exp_q_empty",  32'(exp_q.size()), 32'd0);
        check("mis_q_empty",  32'(mis_q.size()), 32'd0);
        check("completions",  32'(completed),    32'(issued));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
